// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefaultAw = 32;
  localparam int unsigned DefaultDw = 32;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Tie-break between the CPU and loader requests.
// ARB_RR_EN selects round-robin on ties; otherwise the CPU always wins.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic owner,
  output logic grant,
  output logic grant_valid
);

`ifndef ARB_RR_EN
  // Owner only matters for round-robin; it is tracked elsewhere for debug.
  logic unused_owner;
  assign unused_owner = owner;
`endif

  always_comb begin
    grant_valid = cpu_req | ldr_req;
    grant       = OWNER_CPU;
    if (cpu_req && ldr_req) begin
`ifdef ARB_RR_EN
      grant = ~owner;
`else
      grant = OWNER_CPU;
`endif
    end else if (ldr_req) begin
      grant = OWNER_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one instruction/data memory between the CPU and the loader port.
// Each access waits MEM_LAT cycles, then acks the grantee for one cycle (ARB_RR_EN: round-robin).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = DefaultAw,
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          cpu_ack_q, ldr_ack_q, mem_rd_q, mem_wr_q, owner_q;

  logic          grant, grant_valid;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  mem_arb_grant u_grant (
    .cpu_req     (cpu_req),
    .ldr_req     (ldr_req),
    .owner       (owner_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_we    = (grant == OWNER_LDR) ? ldr_we    : cpu_we;
    sel_addr  = (grant == OWNER_LDR) ? ldr_addr  : cpu_addr;
    sel_wdata = (grant == OWNER_LDR) ? ldr_wdata : cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      owner_q   <= OWNER_LDR;
    end else begin
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            owner_q  <= grant;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            mem_rd_q <= ~sel_we;
            mem_wr_q <= sel_we;
            cnt_q    <= LatInit;
            state_q  <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!we_q) rdata_q <= mem_rdata;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            cpu_ack_q <= (owner_q == OWNER_CPU);
            ldr_ack_q <= (owner_q == OWNER_LDR);
            state_q   <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign rdata     = rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks on a MEM_LAT=2 arbiter and a random sweep on a MEM_LAT=1 arbiter.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // MEM_LAT=2 instance, driven directly
  logic        a_cpu_req = 0, a_cpu_we = 0, a_ldr_req = 0, a_ldr_we = 0;
  logic [31:0] a_cpu_addr = 0, a_cpu_wdata = 0, a_ldr_addr = 0, a_ldr_wdata = 0;
  logic [31:0] a_mem_rdata = 0;
  logic        a_cpu_ack, a_ldr_ack, a_mem_rd, a_mem_wr, a_busy, a_owner;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_ack(a_cpu_ack),
    .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr), .ldr_wdata(a_ldr_wdata),
    .ldr_ack(a_ldr_ack),
    .rdata(a_rdata), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
  );

  // MEM_LAT=1 instance with a small memory behind it
  logic [1:0]  pend = 2'b00;
  logic        r_we [2] = '{1'b0, 1'b0};
  logic [31:0] r_addr [2] = '{32'd0, 32'd0};
  logic [31:0] r_wdata [2] = '{32'd0, 32'd0};
  logic        b_cpu_ack, b_ldr_ack, b_mem_rd, b_mem_wr, b_busy, b_owner;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [31:0] b_mem [16];

  always @(posedge clk) if (b_mem_wr) b_mem[b_mem_addr[5:2]] <= b_mem_wdata;
  assign b_mem_rdata = b_mem[b_mem_addr[5:2]];

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .cpu_req(pend[0]), .cpu_we(r_we[0]), .cpu_addr(r_addr[0]), .cpu_wdata(r_wdata[0]),
    .cpu_ack(b_cpu_ack),
    .ldr_req(pend[1]), .ldr_we(r_we[1]), .ldr_addr(r_addr[1]), .ldr_wdata(r_wdata[1]),
    .ldr_ack(b_ldr_ack),
    .rdata(b_rdata), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_a_reset();
    check("rst_cpu_ack", 32'(a_cpu_ack), 32'd0);
    check("rst_ldr_ack", 32'(a_ldr_ack), 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    check("rst_mem_rd", 32'(a_mem_rd), 32'd0);
    check("rst_mem_wr", 32'(a_mem_wr), 32'd0);
    check("rst_mem_addr", a_mem_addr, 32'd0);
    check("rst_mem_wdata", a_mem_wdata, 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_owner", 32'(a_owner), 32'd1);
  endtask

  // reference state for the random sweep
  logic [31:0] ref_mem [16];
  logic [15:0] known = '0;

  initial begin
    int exp_order [4];
    int obs_order [4];
    int ack_time [4];
    int n, cc, lc, pc, pl, last, g;
    int issued, acked, last_ack, idx;
    logic [1:0] acks;

    // reset
    tick();
    check_a_reset();
    rst = 1'b0;

    // CPU read of 0x40
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h40; a_mem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_mem_rd", 32'(a_mem_rd), 32'(i < 2));
      check("rd_cpu_ack", 32'(a_cpu_ack), 32'(i == 2));
      check("rd_ldr_ack", 32'(a_ldr_ack), 32'd0);
      if (i < 2) check("rd_mem_addr", a_mem_addr, 32'h40);
      if (a_cpu_ack) a_cpu_req = 0;
    end
    check("rd_rdata", a_rdata, 32'hDEADBEEF);
    check("rd_owner", 32'(a_owner), 32'd0);

    // loader write; rdata must stay untouched
    a_mem_rdata = 32'h0BAD0BAD;
    a_ldr_req = 1; a_ldr_we = 1; a_ldr_addr = 32'h10; a_ldr_wdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wr_mem_wr", 32'(a_mem_wr), 32'(i < 2));
      check("wr_mem_rd", 32'(a_mem_rd), 32'd0);
      check("wr_ldr_ack", 32'(a_ldr_ack), 32'(i == 2));
      check("wr_cpu_ack", 32'(a_cpu_ack), 32'd0);
      if (i < 2) begin
        check("wr_mem_addr", a_mem_addr, 32'h10);
        check("wr_mem_wdata", a_mem_wdata, 32'h12345678);
      end
      if (a_ldr_ack) a_ldr_req = 0;
    end
    check("wr_rdata_kept", a_rdata, 32'hDEADBEEF);
    check("wr_owner", 32'(a_owner), 32'd1);

    // both requesters held for two accesses each; expected order from the arbitration rule
    pc = 2; pl = 2; last = 1;
    for (int k = 0; k < 4; k++) begin
      if (pc > 0 && pl > 0) begin
`ifdef ARB_RR_EN
        g = 1 - last;
`else
        g = 0;
`endif
      end else begin
        g = (pc > 0) ? 0 : 1;
      end
      if (g == 0) pc--; else pl--;
      last = g;
      exp_order[k] = g;
    end
    a_cpu_we = 0; a_cpu_addr = 32'h100; a_ldr_we = 0; a_ldr_addr = 32'h200;
    a_cpu_req = 1; a_ldr_req = 1;
    n = 0; cc = 0; lc = 0;
    for (int t = 0; t < 40 && n < 4; t++) begin
      tick();
      check("arb_ack_excl", 32'(a_cpu_ack & a_ldr_ack), 32'd0);
      if (a_cpu_ack || a_ldr_ack) begin
        obs_order[n] = a_ldr_ack ? 1 : 0;
        ack_time[n] = t;
        check("arb_owner", 32'(a_owner), 32'(obs_order[n]));
        n++;
        if (a_cpu_ack && ++cc == 2) a_cpu_req = 0;
        if (a_ldr_ack && ++lc == 2) a_ldr_req = 0;
      end
    end
    a_cpu_req = 0; a_ldr_req = 0;
    check("arb_ack_count", 32'(n), 32'd4);
    for (int k = 0; k < n; k++) check("arb_order", 32'(obs_order[k]), 32'(exp_order[k]));
    for (int k = 1; k < n; k++) check("arb_spacing", 32'(ack_time[k] - ack_time[k-1]), 32'd4);
    tick();

    // address churn during an access
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h40;
    tick();
    check("churn_addr0", a_mem_addr, 32'h40);
    a_cpu_addr = 32'h80; a_cpu_we = 1; a_cpu_wdata = 32'hFFFF0000;
    tick();
    check("churn_addr1", a_mem_addr, 32'h40);
    check("churn_rd", 32'(a_mem_rd), 32'd1);
    check("churn_wr", 32'(a_mem_wr), 32'd0);
    tick();
    check("churn_ack", 32'(a_cpu_ack), 32'd1);
    a_cpu_req = 0; a_cpu_we = 0;
    tick();

    // reset in the second access cycle aborts the access
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 32'h20; a_cpu_wdata = 32'h0000AAAA;
    tick();
    check("abort_busy", 32'(a_busy), 32'd1);
    tick();
    rst = 1; a_cpu_req = 0; a_cpu_we = 0;
    tick();
    check_a_reset();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_ack", 32'(a_cpu_ack | a_ldr_ack), 32'd0);
    end
    a_ldr_req = 1; a_ldr_we = 0; a_ldr_addr = 32'h30; a_mem_rdata = 32'h5A5A5A5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_ack", 32'(a_ldr_ack), 32'(i == 2));
      if (a_ldr_ack) a_ldr_req = 0;
    end
    check("post_rst_rdata", a_rdata, 32'h5A5A5A5A);
    tick();

    // random interleaved sweep on the MEM_LAT=1 instance
    issued = 0; acked = 0; last_ack = -100;
    for (int cyc = 0; cyc < 4000 && !(issued == 100 && acked >= 100 && pend == 2'b00); cyc++) begin
      tick();
      acks = {b_ldr_ack, b_cpu_ack};
      check("sw_strobe_excl", 32'(b_mem_rd & b_mem_wr), 32'd0);
      check("sw_ack_excl", 32'(acks == 2'b11), 32'd0);
      for (int r = 0; r < 2; r++) begin
        if (acks[r]) begin
          check("sw_ack_pending", 32'(pend[r]), 32'd1);
          check("sw_ack_spacing", 32'((cyc - last_ack) >= 3), 32'd1);
          last_ack = cyc;
          idx = int'(r_addr[r][5:2]);
          if (r_we[r]) begin
            ref_mem[idx] = r_wdata[r];
            known[idx] = 1'b1;
          end else if (known[idx]) begin
            check("sw_read_data", b_rdata, ref_mem[idx]);
          end
          pend[r] = 1'b0;
          acked++;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && issued < 100 && $urandom_range(0, 2) != 0) begin
          r_we[r] = 1'($urandom_range(0, 1));
          r_addr[r] = 32'($urandom_range(0, 15)) << 2;
          r_wdata[r] = $urandom;
          pend[r] = 1'b1;
          issued++;
        end
      end
    end
    check("sw_issued", 32'(issued), 32'd100);
    check("sw_acked", 32'(acked), 32'd100);
    check("sw_none_pending", 32'(pend), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
